// File: rtl/shift_seq_ctrl_if.sv
// Request channel into the shift-register sequencer: a word plus frame mode,
// transferred on req_valid & req_ready.
interface shift_seq_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic [15:0] req_data;
   logic        req_byte;

   modport master (output req_valid, output req_data, output req_byte, input req_ready);
   modport slave  (input req_valid, input req_data, input req_byte, output req_ready);
endinterface

// File: rtl/shift_seq_ctrl.sv
// Sequencer for an external 16-bit left-shifting register: loads a word, then
// paces one bit per BIT_CYCLES clocks with single-cycle shift pulses.
module shift_seq_ctrl #(
   parameter int BIT_CYCLES = 4
) (
   input  logic              clk,
   input  logic              reset,
   shift_seq_ctrl_if.slave   req,
   input  logic              abort,
   output logic [15:0]       sr_data,
   output logic              sr_data_en,
   output logic              sr_shift_en,
   output logic              sr_reset_n,
   input  logic              sr_msb,
   input  logic              sr_msb7,
   output logic              ser_bit,
   output logic              ser_strobe,
   output logic [3:0]        bit_idx,
   output logic              busy,
   output logic              done,
   output logic              aborted
);

   localparam logic [7:0] CNT_LAST = 8'(BIT_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_BIT, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [3:0]  bit_idx_q, bit_idx_d;
   logic [15:0] word_q, word_d;
   logic        byte_q, byte_d;
   logic        abort_go, next_period;

   logic        req_ready_q, req_ready_d;
   logic        sr_data_en_q, sr_data_en_d;
   logic        sr_shift_en_q, sr_shift_en_d;
   logic        sr_reset_n_q, sr_reset_n_d;
   logic        ser_strobe_q, ser_strobe_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        aborted_q, aborted_d;

   // State register; every output except ser_bit comes straight from a flop.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         bit_idx_q     <= '0;
         word_q        <= '0;
         byte_q        <= 1'b0;
         req_ready_q   <= 1'b0;
         sr_data_en_q  <= 1'b0;
         sr_shift_en_q <= 1'b0;
         sr_reset_n_q  <= 1'b0;
         ser_strobe_q  <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         aborted_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         bit_idx_q     <= bit_idx_d;
         word_q        <= word_d;
         byte_q        <= byte_d;
         req_ready_q   <= req_ready_d;
         sr_data_en_q  <= sr_data_en_d;
         sr_shift_en_q <= sr_shift_en_d;
         sr_reset_n_q  <= sr_reset_n_d;
         ser_strobe_q  <= ser_strobe_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         aborted_q     <= aborted_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_idx_d   = bit_idx_q;
      word_d      = word_q;
      byte_d      = byte_q;
      abort_go    = 1'b0;
      next_period = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req.req_valid && req_ready_q) begin
               state_d   = S_LOAD;
               word_d    = req.req_byte ? {8'h00, req.req_data[7:0]} : req.req_data;
               byte_d    = req.req_byte;
               bit_idx_d = req.req_byte ? 4'd7 : 4'd15;
               cnt_d     = '0;
            end
         end
         S_LOAD: begin
            if (abort) begin
               abort_go  = 1'b1;
               state_d   = S_IDLE;
               bit_idx_d = '0;
            end else begin
               state_d = S_BIT;
            end
            cnt_d = '0;
         end
         S_BIT: begin
            // Abort takes precedence over the end of the final period.
            if (abort) begin
               abort_go  = 1'b1;
               state_d   = S_IDLE;
               bit_idx_d = '0;
               cnt_d     = '0;
            end else if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (bit_idx_q == 4'd0) begin
                  state_d = S_DONE;
               end else begin
                  bit_idx_d   = bit_idx_q - 4'd1;
                  next_period = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs are derived from the upcoming state so they line up with it once registered.
   always_comb begin
      req_ready_d   = (state_d == S_IDLE) && !abort_go;
      sr_reset_n_d  = !abort_go;
      sr_data_en_d  = (state_d == S_LOAD);
      sr_shift_en_d = next_period;
      ser_strobe_d  = (state_d == S_BIT) && (cnt_d == CNT_LAST);
      busy_d        = (state_d == S_LOAD) || (state_d == S_BIT);
      done_d        = (state_d == S_DONE);
      aborted_d     = abort_go;
   end

   assign req.req_ready = req_ready_q;
   assign sr_data       = word_q;
   assign sr_data_en    = sr_data_en_q;
   assign sr_shift_en   = sr_shift_en_q;
   assign sr_reset_n    = sr_reset_n_q;
   assign ser_strobe    = ser_strobe_q;
   assign bit_idx       = bit_idx_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign aborted       = aborted_q;
   assign ser_bit       = byte_q ? sr_msb7 : sr_msb;

endmodule
